// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder sequencer.
// The master drives operands and out_ready; the slave returns the result.
interface nibble_serial_adder_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         result_cout;

  modport master (
    output in_valid, op_a, op_b, op_cin, out_ready,
    input  in_ready, out_valid, result, result_cout
  );

  modport slave (
    input  in_valid, op_a, op_b, op_cin, out_ready,
    output in_ready, out_valid, result, result_cout
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequences a W-bit addition through an external 4-bit adder slice, one nibble
// per cycle, with the carry chained in a register between slices.
module nibble_serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  nibble_serial_adder_ctrl_if.slave  bus,
  output logic [3:0]                 add_a,
  output logic [3:0]                 add_b,
  output logic                       add_cin,
  input  logic [3:0]                 add_sum,
  input  logic                       add_cout,
  output logic                       busy
);
  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             carry_q,     carry_d;
  logic [W-1:0]     a_sh_q,      a_sh_d;
  logic [W-1:0]     b_sh_q,      b_sh_d;
  logic [W-1:0]     res_sh_q,    res_sh_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;

  // Next-state, datapath and adder drive.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    add_a    = 4'd0;
    add_b    = 4'd0;
    add_cin  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d  = S_RUN;
          a_sh_d   = bus.op_a;
          b_sh_d   = bus.op_b;
          carry_d  = bus.op_cin;
          res_sh_d = '0;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        add_a    = a_sh_q[3:0];
        add_b    = b_sh_q[3:0];
        add_cin  = carry_q;
        // New nibble enters at the top so nibble 0 lands in the LSBs at the end.
        res_sh_d = (res_sh_q >> 4) | (W'(add_sum) << (W - 4));
        carry_d  = add_cout;
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Result registers persist through IDLE until the next accept clears them.
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = res_sh_q;
  assign bus.result_cout = carry_q;
  assign busy            = busy_q;
endmodule
